// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: ALU/memory merge with a memory-result FIFO and a pending scoreboard.
// ALU 1 cycle, memory >=2 cycles; mem_ready drops when the FIFO is full. Optional forwarding via RF_WB_BYPASS_EN.
module rf_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        res_valid,
    input  logic [4:0]  res_addr,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        busy1,
    output logic        busy2,
`ifdef RF_WB_BYPASS_EN
    output logic        fwd1_valid,
    output logic        fwd2_valid,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data,
`endif
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [4:0]    fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          rf_wen_q, rf_wen_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic [31:0]   pending_q, pending_d;

    logic          full;
    logic          push;
    logic          pop;

    assign full      = (count_q == FULL_CNT);
    assign mem_ready = !full && !reset;
    assign push      = mem_valid && mem_ready;
    // Pop decision uses registered occupancy only, so a fresh push never falls through.
    assign pop       = !alu_valid && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_valid) begin
            rf_wen_d   = (alu_addr != 5'd0);
            rf_waddr_d = alu_addr;
            rf_wdata_d = alu_data;
        end else if (pop) begin
            rf_wen_d   = (fifo_addr_q[rd_ptr_q] != 5'd0);
            rf_waddr_d = fifo_addr_q[rd_ptr_q];
            rf_wdata_d = fifo_data_q[rd_ptr_q];
        end
    end

    // Clear is applied first so a same-cycle reservation of the committing register wins.
    always_comb begin
        pending_d = pending_q;
        if (rf_wen_q) begin
            pending_d[rf_waddr_q] = 1'b0;
        end
        if (res_valid && (res_addr != 5'd0)) begin
            pending_d[res_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            pending_q  <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= mem_addr;
            fifo_data_q[wr_ptr_q] <= mem_data;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef RF_WB_BYPASS_EN
    assign fwd1_valid = rf_wen_q && (rf_waddr_q == q_addr1) && (q_addr1 != 5'd0);
    assign fwd2_valid = rf_wen_q && (rf_waddr_q == q_addr2) && (q_addr2 != 5'd0);
    assign fwd1_data  = rf_wdata_q;
    assign fwd2_data  = rf_wdata_q;
    assign busy1      = pending_q[q_addr1] && !fwd1_valid;
    assign busy2      = pending_q[q_addr2] && !fwd2_valid;
`else
    assign busy1      = pending_q[q_addr1];
    assign busy2      = pending_q[q_addr2];
`endif

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-back controller that drives the write port of the 32×32 CPU register file. It merges results from the single-cycle ALU path and the variable-latency memory path, buffering memory results in a small FIFO when the ALU wins arbitration. It also keeps a per-register pending scoreboard that the issue stage queries for read-after-write hazards. It sits between the execute/memory stages and the register file, and is the only source of `rf_wen`, `rf_waddr` and `rf_wdata`.

## Interface
- `DEPTH`, default 4: memory-result FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no ready.
- `alu_addr`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `mem_valid`  in  1  memory result offered.
- `mem_ready`  out  1  FIFO can accept; transfer on `mem_valid && mem_ready`.
- `mem_addr`  in  5  memory destination register.
- `mem_data`  in  32  memory result.
- `res_valid`  in  1  issue stage reserves a destination.
- `res_addr`  in  5  reserved destination register.
- `q_addr1`, `q_addr2`  in  5 each  hazard query addresses (same as RF read addresses).
- `busy1`, `busy2`  out  1 each  pending status for `q_addr1`/`q_addr2`.
- `rf_wen`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.

## Operation
- Arbitration each cycle: `alu_valid` has strict priority. Otherwise, if the FIFO is non-empty, pop its head. Otherwise, select nothing.
- The selected write is registered onto `rf_wen/rf_waddr/rf_wdata` at the next edge. With no selection, `rf_wen`=0 and address/data hold their previous values.
- Writes to register 0:
  - An ALU write to addr 0 produces `rf_wen`=0.
  - A memory write to addr 0 is accepted into the FIFO and popped normally, but produces `rf_wen`=0.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo `DEPTH`, plus an occupancy count of 0..`DEPTH`.
  - Push and pop may occur in the same cycle; the count is then unchanged.
  - `mem_ready` = !full && !reset (combinational).
  - A push into an empty FIFO is never popped in the same cycle; there is no fall-through.
- Scoreboard: 32-bit `pending` vector, with bit 0 hard-wired to 0.
  - Set: `res_valid && res_addr!=0` sets `pending[res_addr]`.
  - Clear: a cycle with `rf_wen`=1 clears `pending[rf_waddr]` at the edge where the register file performs the write.
  - Set and clear of the same bit in the same cycle: set wins.
  - Reserving an already-pending register leaves it at 1, with no counting. The issue stage must not do this.
- Query: `busyN = pending[q_addrN]` (combinational); 0 when `q_addrN`=0.

## Timing
- Reset (synchronous, one edge with `reset`=1) sets:
  - `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0;
  - FIFO empty, pointers 0;
  - `pending`=0 (hence `busy1`/`busy2`=0);
  - `mem_ready`=0 while `reset` is high.
- Reset asserted mid-operation discards all FIFO contents and pending bits. No `rf_wen` occurs on the cycle after the reset edge.
- ALU latency: `alu_valid` in cycle N → `rf_wen`=1 in cycle N+1 → register file updated at the end of N+1 → `pending` cleared at the end of N+1.
- Memory latency: minimum 2 cycles (accept in N, pop in N+1, `rf_wen` in N+2). The added delay is unbounded while `alu_valid` stays high.
- FIFO full: `mem_ready`=0 in the same cycle. Accepting again requires a pop in the previous cycle.
- FIFO order is strictly FIFO. ALU and memory writes may interleave in any order.

## Configuration
- `RF_WB_BYPASS_EN` defined adds outputs `fwd1_valid`, `fwd2_valid` (1 bit each) and `fwd1_data`, `fwd2_data` (32 bits each).
  - `fwdN_valid = rf_wen && rf_waddr==q_addrN && q_addrN!=0`.
  - `fwdN_data = rf_wdata`.
  - Purpose: covers the cycle in which the register file still returns the old value.
  - In that cycle `busyN` is forced to 0, so a consumer can issue one cycle earlier.
- Undefined: these ports do not exist, and `busyN` stays 1 until the write has committed.

## Test plan
- Reset mid-stream with 3 FIFO entries held:
  - next cycle: `rf_wen`=0, `mem_ready`=0 during reset, `busy1`=0 for every `q_addr1`;
  - after release: `mem_ready`=1.
- Reserve r5, then `alu_valid` (r5, 0x12345678) in cycle N:
  - `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x12345678 in N+1;
  - `busy1`(q=5)=1 through N+1, 0 from N+2.
- `alu_valid` held high 6 cycles while memory offers r1..r6 with data 0x11..0x66:
  - `mem_ready` drops after 4 accepts (`DEPTH`=4);
  - after the ALU stops, writes r1..r4 appear in order on consecutive cycles, then r5, r6.
- Same-cycle `res_valid` r7 and `rf_wen` committing r7: `pending[7]` stays 1.
- ALU write to r0 with data 0xFFFFFFFF, and memory write to r0: `rf_wen` stays 0; `busy1`(q=0)=0.
- With `RF_WB_BYPASS_EN`, `alu_valid` (r9, 0xDEADBEEF) in N:
  - in N+1, `q_addr1`=9 gives `fwd1_valid`=1, `fwd1_data`=0xDEADBEEF, `busy1`=0.
